// File: rtl/superscalar_pkg.sv
// Shared types for the superscalar front end.
//   instr_meta_t : decoded instruction metadata carried from decode to execute
//   NUM_REGS     : architectural integer register count
//   is_mem()     : true for loads and stores
//   ends_group() : true for control-flow ops that close an issue group
package superscalar_pkg;

   localparam int unsigned NUM_REGS = 32;
   localparam int unsigned REG_W    = 5;

   typedef struct packed {
      logic [REG_W-1:0] rs1;
      logic [REG_W-1:0] rs2;
      logic [REG_W-1:0] rd;
      logic             is_load;
      logic             is_store;
      logic             is_branch;
      logic             is_jump;
      logic [31:0]      pc;
   } instr_meta_t;

   function automatic logic is_mem(input instr_meta_t m);
      return m.is_load | m.is_store;
   endfunction

   function automatic logic ends_group(input instr_meta_t m);
      return m.is_branch | m.is_jump;
   endfunction

endpackage

// File: rtl/issue_window_group_check.sv
// Combinational in-order issue group former.
//   head     : the ISSUE_W oldest buffer entries, slot 0 oldest
//   present  : which of those slots hold a real entry
//   rs1_busy : scoreboard says the slot's rs1 is still waiting on a load
//   rs2_busy : same for rs2
//   group    : prefix-contiguous mask of slots that issue together
module issue_group_check
   import superscalar_pkg::*;
#(
   parameter int unsigned ISSUE_W = 2
) (
   input  instr_meta_t [ISSUE_W-1:0] head,
   input  logic        [ISSUE_W-1:0] present,
   input  logic        [ISSUE_W-1:0] rs1_busy,
   input  logic        [ISSUE_W-1:0] rs2_busy,
   output logic        [ISSUE_W-1:0] group
);

   // An older group member prevents the younger one from joining the group.
   function automatic logic pair_blocks(input instr_meta_t older, input instr_meta_t younger);
      logic raw;
      logic waw;
      raw = (older.rd != '0) && ((younger.rs1 == older.rd) || (younger.rs2 == older.rd));
      waw = (older.rd != '0) && (younger.rd == older.rd);
      return raw | waw | (is_mem(older) & is_mem(younger)) | ends_group(older);
   endfunction

   // Walk slots oldest first; the first blocked slot ends the group.
   always_comb begin : form_group
      logic chain;
      logic ok;
      group = '0;
      chain = 1'b1;
      ok    = 1'b0;
      for (int unsigned k = 0; k < ISSUE_W; k++) begin
         ok = chain && present[k] && !rs1_busy[k] && !rs2_busy[k];
         for (int unsigned j = 0; j < ISSUE_W; j++) begin
            if ((j < k) && pair_blocks(head[j], head[k])) ok = 1'b0;
         end
         group[k] = ok;
         chain    = ok;
      end
   end

endmodule

// File: rtl/issue_window.sv
// In-order issue window between decode and execute.
//   clk, rst     : single clock, synchronous active-high reset
//   flush        : drop every buffered entry (scoreboard keeps in-flight loads)
//   in_valid     : prefix-contiguous per-slot push valid
//   in_instr     : decoded metadata per push slot, slot 0 oldest
//   in_ready     : a full ISSUE_W push fits this cycle
//   out_valid    : issue group mask over the head entries
//   out_instr    : the ISSUE_W head entries
//   out_ready    : execute takes every out_valid slot
//   stall_cycles : saturating count of cycles with work but nothing issuing
module issue_window
   import superscalar_pkg::*;
#(
   parameter int unsigned ISSUE_W  = 2,
   parameter int unsigned DEPTH    = 8,
   parameter int unsigned LOAD_LAT = 2
) (
   input  logic                      clk,
   input  logic                      rst,
   input  logic                      flush,
   input  logic        [ISSUE_W-1:0] in_valid,
   input  instr_meta_t [ISSUE_W-1:0] in_instr,
   output logic                      in_ready,
   output logic        [ISSUE_W-1:0] out_valid,
   output instr_meta_t [ISSUE_W-1:0] out_instr,
   input  logic                      out_ready,
   output logic        [31:0]        stall_cycles
);

   localparam int unsigned PTR_W  = $clog2(DEPTH);
   localparam int unsigned CNT_W  = PTR_W + 1;
   localparam int unsigned BUSY_W = $clog2(LOAD_LAT) + 1;
   localparam logic [CNT_W-1:0]  ROOM_LIMIT = CNT_W'(DEPTH - ISSUE_W);
   localparam logic [BUSY_W-1:0] BUSY_INIT  = BUSY_W'(LOAD_LAT - 1);

   instr_meta_t        mem [DEPTH];
   logic [PTR_W-1:0]   head;
   logic [PTR_W-1:0]   tail;
   logic [CNT_W-1:0]   count;
   logic [BUSY_W-1:0]  busy [NUM_REGS];

   logic [ISSUE_W-1:0] present;
   logic [ISSUE_W-1:0] rs1_busy;
   logic [ISSUE_W-1:0] rs2_busy;
   logic [CNT_W-1:0]   push_n;
   logic [CNT_W-1:0]   pop_n;
   logic               sb_set;
   logic [REG_W-1:0]   sb_rd;

   // Room check uses only the registered count, so a same-cycle pop never opens space.
   assign in_ready = (count <= ROOM_LIMIT);

   // Head view and scoreboard lookups; depends only on registered state.
   always_comb begin
      out_instr = '0;
      present   = '0;
      rs1_busy  = '0;
      rs2_busy  = '0;
      for (int unsigned k = 0; k < ISSUE_W; k++) begin
         out_instr[k] = mem[head + PTR_W'(k)];
         present[k]   = (count > CNT_W'(k));
         rs1_busy[k]  = (out_instr[k].rs1 != '0) && (busy[out_instr[k].rs1] != '0);
         rs2_busy[k]  = (out_instr[k].rs2 != '0) && (busy[out_instr[k].rs2] != '0);
      end
   end

   issue_group_check #(
      .ISSUE_W (ISSUE_W)
   ) u_group (
      .head     (out_instr),
      .present  (present),
      .rs1_busy (rs1_busy),
      .rs2_busy (rs2_busy),
      .group    (out_valid)
   );

   // Push/pop amounts and the (at most one) load issued this cycle.
   always_comb begin
      push_n = '0;
      pop_n  = '0;
      sb_set = 1'b0;
      sb_rd  = '0;
      for (int unsigned k = 0; k < ISSUE_W; k++) begin
         if (in_ready && in_valid[k]) push_n = push_n + CNT_W'(1);
         if (out_ready && out_valid[k]) begin
            pop_n = pop_n + CNT_W'(1);
            if (out_instr[k].is_load && (out_instr[k].rd != '0)) begin
               sb_set = 1'b1;
               sb_rd  = out_instr[k].rd;
            end
         end
      end
   end

   // Pointers and occupancy; flush behaves like an empty restart.
   always_ff @(posedge clk) begin
      if (rst) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else if (flush) begin
         head  <= '0;
         tail  <= '0;
         count <= '0;
      end else begin
         head  <= head + PTR_W'(pop_n);
         tail  <= tail + PTR_W'(push_n);
         count <= count + push_n - pop_n;
      end
   end

   // Entry storage; contents are don't-care until count covers them.
   always_ff @(posedge clk) begin
      if (!rst && !flush && in_ready) begin
         for (int unsigned k = 0; k < ISSUE_W; k++) begin
            if (in_valid[k]) mem[tail + PTR_W'(k)] <= in_instr[k];
         end
      end
   end

   // Load-use scoreboard; a new load to the same rd wins over the countdown.
   always_ff @(posedge clk) begin
      if (rst) begin
         for (int unsigned r = 0; r < NUM_REGS; r++) busy[r] <= '0;
      end else begin
         for (int unsigned r = 0; r < NUM_REGS; r++) begin
            if (sb_set && (sb_rd == REG_W'(r))) busy[r] <= BUSY_INIT;
            else if (busy[r] != '0)            busy[r] <= busy[r] - BUSY_W'(1);
         end
      end
   end

   // Stall counter: entries waiting but the head cannot go.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cycles <= '0;
      end else if ((count != '0) && !out_valid[0] && !flush && (stall_cycles != '1)) begin
         stall_cycles <= stall_cycles + 32'd1;
      end
   end

endmodule

// File: tb/tb_issue_window.sv
// Self-checking bench for issue_window: table-driven pair tests, hand sequences
// for multi-cycle cases, then random traffic against a queue-based model.
// LOAD_LAT is 3 here so a load issued in a flush cycle is still in flight
// when a dependent pushed after the flush reaches the head.
module tb_issue_window;
   import superscalar_pkg::*;

   localparam int unsigned IW    = 2;
   localparam int unsigned DEPTH = 8;
   localparam int unsigned LL    = 3;
   localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_JMP = 4;

   typedef instr_meta_t [IW-1:0] grp_t;
   typedef struct {
      instr_meta_t i0;
      instr_meta_t i1;
      logic [1:0]  exp;
   } vec_t;

   logic          clk = 1'b0;
   logic          rst;
   logic          flush;
   logic [IW-1:0] in_valid;
   grp_t          in_instr;
   logic          in_ready;
   logic [IW-1:0] out_valid;
   grp_t          out_instr;
   logic          out_ready;
   logic [31:0]   stall_cycles;

   always #5 clk = ~clk;

   issue_window #(.ISSUE_W(IW), .DEPTH(DEPTH), .LOAD_LAT(LL)) dut (
      .clk          (clk),
      .rst          (rst),
      .flush        (flush),
      .in_valid     (in_valid),
      .in_instr     (in_instr),
      .in_ready     (in_ready),
      .out_valid    (out_valid),
      .out_instr    (out_instr),
      .out_ready    (out_ready),
      .stall_cycles (stall_cycles)
   );

   int            n_cmp;
   int            n_bad;
   instr_meta_t   mq[$];
   int            mbusy [NUM_REGS];
   longint        mstall;
   logic [IW-1:0] seen_ov;
   logic          seen_rdy;
   longint        seen_stall;

   task automatic chk(input string name, input longint act, input longint exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic instr_meta_t mk(input int kind, input int rd, input int rs1, input int rs2);
      instr_meta_t m;
      m           = '0;
      m.rd        = 5'(rd);
      m.rs1       = 5'(rs1);
      m.rs2       = 5'(rs2);
      m.is_load   = (kind == K_LD);
      m.is_store  = (kind == K_ST);
      m.is_branch = (kind == K_BR);
      m.is_jump   = (kind == K_JMP);
      m.pc        = $urandom();
      return m;
   endfunction

   function automatic instr_meta_t alu(input int rd);
      return mk(K_ALU, rd, 1, 2);
   endfunction

   function automatic grp_t g(input instr_meta_t a, input instr_meta_t b);
      grp_t r;
      r[0] = a;
      r[1] = b;
      return r;
   endfunction

   function automatic instr_meta_t rand_instr();
      int t;
      t = int'($urandom_range(0, 9));
      case (t)
         0, 1:    return mk(K_LD, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), 0);
         2:       return mk(K_ST, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         3:       return mk(K_BR, 0, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
         4:       return mk(K_JMP, int'($urandom_range(0, 1)), int'($urandom_range(0, 7)), 0);
         default: return mk(K_ALU, int'($urandom_range(0, 7)), int'($urandom_range(0, 7)),
                            int'($urandom_range(0, 7)));
      endcase
   endfunction

   // Spec rules applied to the front of the model queue.
   function automatic logic [IW-1:0] model_group();
      logic [IW-1:0] grp;
      instr_meta_t   c;
      instr_meta_t   o;
      bit            ok;
      grp = '0;
      for (int k = 0; k < int'(IW) && k < mq.size(); k++) begin
         c  = mq[k];
         ok = 1;
         if (c.rs1 != 0 && mbusy[c.rs1] > 0) ok = 0;
         if (c.rs2 != 0 && mbusy[c.rs2] > 0) ok = 0;
         for (int j = 0; j < k; j++) begin
            o = mq[j];
            if (o.rd != 0 && (c.rs1 == o.rd || c.rs2 == o.rd || c.rd == o.rd)) ok = 0;
            if ((o.is_load || o.is_store) && (c.is_load || c.is_store)) ok = 0;
            if (o.is_branch || o.is_jump) ok = 0;
         end
         if (!ok) break;
         grp[k] = 1'b1;
      end
      return grp;
   endfunction

   function automatic bit model_ready();
      return mq.size() <= int'(DEPTH - IW);
   endfunction

   // One clock: drive, compare against the model, clock, advance the model.
   task automatic cycle(input logic [IW-1:0] iv, input grp_t ii, input logic ordy,
                        input logic fl, input logic rs);
      logic [IW-1:0] eov;
      bit            erdy;
      int            setr;
      in_valid  = iv;
      in_instr  = ii;
      out_ready = ordy;
      flush     = fl;
      rst       = rs;
      #1;
      eov  = model_group();
      erdy = model_ready();
      seen_ov    = out_valid;
      seen_rdy   = in_ready;
      seen_stall = longint'(stall_cycles);
      chk("out_valid", longint'(out_valid), longint'(eov));
      chk("in_ready", longint'(in_ready), longint'(erdy));
      chk("stall_cycles", longint'(stall_cycles), mstall);
      for (int k = 0; k < int'(IW); k++) begin
         if (eov[k]) chk($sformatf("out_instr[%0d]", k), longint'(out_instr[k]), longint'(mq[k]));
      end
      @(posedge clk);
      if (rs) begin
         mq.delete();
         for (int r = 0; r < int'(NUM_REGS); r++) mbusy[r] = 0;
         mstall = 0;
      end else begin
         if (mq.size() != 0 && !eov[0] && !fl && mstall < 64'hFFFF_FFFF) mstall++;
         setr = -1;
         for (int k = 0; k < int'(IW); k++) begin
            if (ordy && eov[k] && mq[k].is_load && mq[k].rd != 0) setr = int'(mq[k].rd);
         end
         for (int r = 0; r < int'(NUM_REGS); r++) begin
            if (r == setr)        mbusy[r] = int'(LL) - 1;
            else if (mbusy[r] > 0) mbusy[r]--;
         end
         if (fl) begin
            mq.delete();
         end else begin
            for (int k = 0; k < int'(IW); k++) if (ordy && eov[k]) void'(mq.pop_front());
            if (erdy) for (int k = 0; k < int'(IW); k++) if (iv[k]) mq.push_back(ii[k]);
         end
      end
      #1;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      vec_t          tbl [12];
      grp_t          nop2;
      grp_t          gi;
      logic [IW-1:0] iv;
      longint        s0;
      int            n;

      n_cmp = 0;
      n_bad = 0;
      nop2  = g(mk(K_ALU, 0, 0, 0), mk(K_ALU, 0, 0, 0));
      tbl[0]  = '{alu(5),                mk(K_ALU, 6, 1, 2),  2'b11};
      tbl[1]  = '{alu(5),                mk(K_ALU, 8, 5, 2),  2'b01};
      tbl[2]  = '{alu(5),                mk(K_ALU, 8, 2, 5),  2'b01};
      tbl[3]  = '{mk(K_ALU, 0, 1, 2),    mk(K_ALU, 8, 0, 0),  2'b11};
      tbl[4]  = '{alu(5),                mk(K_ALU, 5, 3, 4),  2'b01};
      tbl[5]  = '{mk(K_LD, 5, 1, 2),     mk(K_ST, 0, 2, 3),   2'b01};
      tbl[6]  = '{mk(K_ST, 0, 2, 3),     mk(K_LD, 9, 3, 0),   2'b01};
      tbl[7]  = '{mk(K_BR, 0, 1, 2),     alu(6),              2'b01};
      tbl[8]  = '{alu(5),                mk(K_BR, 0, 1, 2),   2'b11};
      tbl[9]  = '{mk(K_JMP, 1, 2, 0),    mk(K_ALU, 6, 2, 3),  2'b01};
      tbl[10] = '{mk(K_LD, 5, 1, 2),     alu(6),              2'b11};
      tbl[11] = '{mk(K_ST, 0, 2, 3),     alu(6),              2'b11};

      rst = 1'b1; flush = 1'b0; out_ready = 1'b0; in_valid = '0; in_instr = '0;
      mq.delete();
      for (int r = 0; r < int'(NUM_REGS); r++) mbusy[r] = 0;
      mstall = 0;
      repeat (2) @(posedge clk);
      #1;
      chk("reset_out_valid", longint'(out_valid), 0);
      chk("reset_in_ready", longint'(in_ready), 1);
      chk("reset_stall", longint'(stall_cycles), 0);

      // Group formation over a pushed pair, cleared by flush each time.
      for (int i = 0; i < 12; i++) begin
         cycle(2'b11, g(tbl[i].i0, tbl[i].i1), 1'b0, 1'b0, 1'b0);
         cycle(2'b00, nop2, 1'b0, 1'b1, 1'b0);
         chk($sformatf("table%0d", i), longint'(seen_ov), longint'(tbl[i].exp));
      end

      // Independent pair issues the cycle after the push, then buffer is empty.
      cycle(2'b11, g(alu(5), alu(6)), 1'b1, 1'b0, 1'b0);
      cycle(2'b00, nop2, 1'b1, 1'b0, 1'b0);
      chk("pair_issue", longint'(seen_ov), 2'b11);
      cycle(2'b00, nop2, 1'b1, 1'b0, 1'b0);
      chk("pair_drained_ov", longint'(seen_ov), 0);
      chk("pair_drained_rdy", longint'(seen_rdy), 1);

      // RAW pair issues one per cycle; with rd = x0 it issues together.
      cycle(2'b11, g(alu(5), mk(K_ALU, 8, 5, 2)), 1'b1, 1'b0, 1'b0);
      cycle(2'b00, nop2, 1'b1, 1'b0, 1'b0);
      chk("raw_first", longint'(seen_ov), 2'b01);
      cycle(2'b00, nop2, 1'b1, 1'b0, 1'b0);
      chk("raw_second", longint'(seen_ov), 2'b01);
      cycle(2'b11, g(mk(K_ALU, 0, 1, 2), mk(K_ALU, 8, 0, 2)), 1'b1, 1'b0, 1'b0);
      cycle(2'b00, nop2, 1'b1, 1'b0, 1'b0);
      chk("x0_pair", longint'(seen_ov), 2'b11);

      // Load-use: dependent waits LL-1 cycles behind its load.
      cycle(2'b01, g(mk(K_LD, 7, 1, 2), nop2[1]), 1'b1, 1'b0, 1'b0);
      cycle(2'b01, g(mk(K_ALU, 8, 7, 1), nop2[1]), 1'b1, 1'b0, 1'b0);
      chk("lu_load", longint'(seen_ov), 2'b01);
      s0 = seen_stall;
      cycle(2'b00, nop2, 1'b1, 1'b0, 1'b0);
      chk("lu_block1", longint'(seen_ov), 0);
      cycle(2'b00, nop2, 1'b1, 1'b0, 1'b0);
      chk("lu_block2", longint'(seen_ov), 0);
      cycle(2'b00, nop2, 1'b1, 1'b0, 1'b0);
      chk("lu_issue", longint'(seen_ov), 2'b01);
      chk("lu_stall", seen_stall - s0, 2);

      // Move both pointers to 7, then fill across the wrap.
      cycle(2'b00, nop2, 1'b0, 1'b1, 1'b0);
      cycle(2'b11, g(alu(10), alu(11)), 1'b1, 1'b0, 1'b0);
      cycle(2'b11, g(alu(12), alu(13)), 1'b1, 1'b0, 1'b0);
      cycle(2'b11, g(alu(14), alu(15)), 1'b1, 1'b0, 1'b0);
      cycle(2'b01, g(alu(16), nop2[1]), 1'b1, 1'b0, 1'b0);
      cycle(2'b00, nop2, 1'b1, 1'b0, 1'b0);
      cycle(2'b11, g(alu(17), alu(18)), 1'b0, 1'b0, 1'b0);
      cycle(2'b11, g(alu(19), alu(20)), 1'b0, 1'b0, 1'b0);
      cycle(2'b11, g(alu(21), alu(22)), 1'b0, 1'b0, 1'b0);
      cycle(2'b01, g(alu(23), nop2[1]), 1'b0, 1'b0, 1'b0);
      chk("fill6_rdy", longint'(seen_rdy), 1);
      cycle(2'b00, nop2, 1'b1, 1'b0, 1'b0);
      chk("fill7_rdy", longint'(seen_rdy), 0);
      chk("wrap_group", longint'(seen_ov), 2'b11);
      cycle(2'b01, g(alu(24), nop2[1]), 1'b0, 1'b0, 1'b0);
      cycle(2'b11, g(alu(25), alu(26)), 1'b0, 1'b0, 1'b0);
      cycle(2'b00, nop2, 1'b1, 1'b0, 1'b0);
      chk("full8_rdy", longint'(seen_rdy), 0);
      cycle(2'b00, nop2, 1'b0, 1'b1, 1'b0);

      // Flush with 5 entries and a push; the in-flight load still blocks x7 readers.
      cycle(2'b11, g(mk(K_LD, 7, 1, 2), alu(11)), 1'b0, 1'b0, 1'b0);
      cycle(2'b11, g(alu(12), alu(13)), 1'b0, 1'b0, 1'b0);
      cycle(2'b01, g(alu(14), nop2[1]), 1'b0, 1'b0, 1'b0);
      cycle(2'b11, g(alu(15), alu(16)), 1'b1, 1'b1, 1'b0);
      chk("fl_group", longint'(seen_ov), 2'b11);
      cycle(2'b01, g(mk(K_ALU, 8, 7, 1), nop2[1]), 1'b1, 1'b0, 1'b0);
      chk("fl_empty_ov", longint'(seen_ov), 0);
      chk("fl_empty_rdy", longint'(seen_rdy), 1);
      cycle(2'b00, nop2, 1'b1, 1'b0, 1'b0);
      chk("fl_busy_block", longint'(seen_ov), 0);
      cycle(2'b00, nop2, 1'b1, 1'b0, 1'b0);
      chk("fl_dep_issue", longint'(seen_ov), 2'b01);

      // Reset overrides flush, push and pop in the same cycle.
      cycle(2'b11, g(alu(5), alu(6)), 1'b0, 1'b0, 1'b0);
      cycle(2'b11, g(alu(5), alu(6)), 1'b1, 1'b1, 1'b1);
      cycle(2'b00, nop2, 1'b0, 1'b0, 1'b0);
      chk("rst_mid_ov", longint'(seen_ov), 0);
      chk("rst_mid_rdy", longint'(seen_rdy), 1);
      chk("rst_mid_stall", seen_stall, 0);

      // Random traffic against the model.
      for (int c = 0; c < 3000; c++) begin
         n  = int'($urandom_range(0, IW));
         iv = '0;
         for (int k = 0; k < n; k++) iv[k] = 1'b1;
         if (!model_ready()) iv = '0;
         for (int k = 0; k < int'(IW); k++) gi[k] = rand_instr();
         cycle(iv, gi, ($urandom_range(0, 3) != 0), ($urandom_range(0, 39) == 0),
               ($urandom_range(0, 299) == 0));
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
